// File: rtl/blockade_pkg.sv
// Shared definitions for the Blockade ROM download path: loader states and
// the address map of the program ROM and graphics PROM image.
package blockade_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } loader_state_e;

  localparam int ADDR_W = 14;

  // Each ROM/PROM is split into separate high and low nibble banks.
  localparam int ROM1_MSB   = 'h0000;
  localparam int ROM1_LSB   = 'h0400;
  localparam int ROM2_MSB   = 'h0800;
  localparam int ROM2_LSB   = 'h0C00;
  localparam int PROM_MSB   = 'h1000;
  localparam int PROM_LSB   = 'h1200;
  localparam int IMAGE_SIZE = 'h1400;

endpackage

// File: rtl/blockade_byte_fifo.sv
// Small byte FIFO with register-array storage, full/empty flags and a
// synchronous flush. No fall-through: a pushed byte is visible the next cycle.
module blockade_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_ok   = pop && !empty;
  // A push into a full FIFO is only taken when a pop frees the slot that cycle.
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/blockade_dn_loader.sv
// Streams a ROM image from the HPS byte source onto the core's download bus,
// pacing write strobes and holding the game in reset until the image is in.
module blockade_dn_loader
  import blockade_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_GAP     = 2,
  parameter int LOAD_SIZE  = IMAGE_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] dn_addr,
  output logic              dn_wr,
  output logic [7:0]        dn_data,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP + 1) : 1;
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(WR_GAP);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LOAD_SIZE - 1);

  if (LOAD_SIZE < 1 || LOAD_SIZE > (1 << ADDR_W)) begin : g_bad_load_size
    $error("blockade_dn_loader: LOAD_SIZE must be 1..16384");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("blockade_dn_loader: FIFO_DEPTH must be a power of two >= 2");
  end
  if (WR_GAP < 0) begin : g_bad_gap
    $error("blockade_dn_loader: WR_GAP must be >= 0");
  end
  if (ROM1_LSB - ROM1_MSB != 'h400 || ROM2_MSB - ROM1_LSB != 'h400 ||
      ROM2_LSB - ROM2_MSB != 'h400 || PROM_MSB - ROM2_LSB != 'h400 ||
      PROM_LSB - PROM_MSB != 'h200 || IMAGE_SIZE - PROM_LSB != 'h200) begin : g_bad_map
    $error("blockade_dn_loader: inconsistent image address map");
  end

  loader_state_e     state;
  loader_state_e     state_next;
  logic [ADDR_W-1:0] counter;
  logic [GAP_W-1:0]  gap;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        last_data;
  logic              fifo_push;
  logic              fifo_pop;
  logic [7:0]        fifo_data;
  logic              fifo_full;
  logic              fifo_empty;

  blockade_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (start),
    .push     (fifo_push),
    .push_data(s_data),
    .pop      (fifo_pop),
    .pop_data (fifo_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start always wins over a waiting byte: no handshake and no write that cycle.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (!start) begin
          s_ready  = !fifo_full;
          fifo_pop = !fifo_empty && (gap == '0);
          if (fifo_pop && counter == LAST_ADDR) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          state_next = LOAD;
        end else begin
          s_ready = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_push = s_valid && s_ready && (state == LOAD);
  assign dn_wr     = fifo_pop;
  assign dn_addr   = fifo_pop ? counter : last_addr;
  assign dn_data   = fifo_pop ? fifo_data : last_data;
  assign busy      = (state == LOAD);
  assign done      = (state == DONE);

  // The counter stops on the final write so it never wraps at LOAD_SIZE=16384.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      gap       <= '0;
      last_addr <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else if (start) begin
      counter  <= '0;
      gap      <= '0;
      overflow <= 1'b0;
    end else begin
      if (fifo_pop) begin
        last_addr <= counter;
        last_data <= fifo_data;
        gap       <= GAP_LOAD;
        if (counter != LAST_ADDR) begin
          counter <= counter + 1'b1;
        end
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (state == DONE && s_valid) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
